lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit on the core side of the data memory interface: the initiator that drives data memory.
//  Takes one load/store per handshake from the pipeline and issues word-aligned memory requests with byte strobes.
//  Returns load data extracted, sign- or zero-extended per funct3 (RV32I LB/LH/LW/LBU/LHU, SB/SH/SW).
//  Sits between the execute stage and a data memory that may take multiple cycles to respond.
// PARAMETERS
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  32  data width; fixed at 32, four byte lanes
// PORTS
//  clk         in   1           clock, all state on rising edge
//  reset       in   1           synchronous, active-high
//  req_valid   in   1           core request valid
//  req_ready   out  1           unit can accept; high only in IDLE
//  req_we      in   1           1 = store, 0 = load
//  req_funct3  in   3           [1:0] size 00=B 01=H 10=W; [2] 1 = unsigned load
//  req_addr    in   ADDR_WIDTH  byte address
//  req_wdata   in   DATA_WIDTH  store data, LSB-aligned
//  resp_valid  out  1           one-cycle pulse: access done (no backpressure)
//  resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
//  resp_err    out  1           valid with resp_valid: misaligned (macro off) or size 11
//  mem_req     out  1           memory request, held until mem_ack
//  mem_we      out  1           memory write
//  mem_addr    out  ADDR_WIDTH  word-aligned address, [1:0] = 00
//  mem_wstrb   out  4           byte lane enables for writes
//  mem_wdata   out  DATA_WIDTH  lane-positioned store data
//  mem_ack     in   1           completes the beat; honoured only while mem_req = 1
//  mem_rdata   in   DATA_WIDTH  read word, valid in the mem_ack cycle
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; resp_valid, resp_err, mem_req, mem_we=0; mem_addr, mem_wstrb, mem_wdata, resp_rdata=0.
//  FSM: IDLE -> BEAT0 -> (BEAT1) -> RESP -> IDLE.
//  IDLE: on req_valid&req_ready, register we/funct3/addr/wdata; off = addr[1:0].
//  Size 11 or misaligned with split disabled: go to RESP with resp_err=1; no memory access.
//  Misaligned means H with off=3, or W with off!=0.
//  BEAT0: mem_req=1, mem_addr={addr[31:2],2'b00}; mem_* outputs stable until mem_ack.
//   On ack, capture mem_rdata as rd0. If split, go to BEAT1, else go to RESP.
//  BEAT1: mem_addr = beat0 address + 4 (wraps modulo 2^ADDR_WIDTH); on ack, capture rd1 and go to RESP.
//  RESP: resp_valid=1 for one cycle, then IDLE. No back-to-back accept in the RESP cycle.
//  Latency: accept at edge T; mem_req high from T+1; with ack in the first request cycle, resp_valid is high in the cycle after the ack.
//  Store lanes: 8-bit mask = {B:0001, H:0011, W:1111} << off; 64-bit data = wdata << 8*off.
//   Beat0 uses the low 4 bits/low 32 bits; beat1 uses the high halves.
//   mem_wstrb = 0 and mem_we = 0 on loads.
//  Load: 64-bit {rd1,rd0} >> 8*off (rd1 = 0 if unsplit).
//   Take the low 8/16/32 bits; sign-extend unless funct3[2]; funct3[2] is ignored for W.
//  reset while mem_req is high drops the transaction next edge; the memory side must tolerate an abandoned request.
//  mem_ack outside BEAT0/BEAT1 is ignored.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined: misaligned H/W are split into two word beats (BEAT1 used), resp_err=0.
//  Undefined: BEAT1 is not compiled; misaligned access is answered with resp_err=1, resp_rdata=0, and no mem_req.
// STRUCTURE
//  Package lsu_pkg: funct3 size constants (SZ_B/SZ_H/SZ_W), LSU state localparams, lane-mask function.
//  Sub-module lsu_align: combinational store lane shift/strobe and load shift/extend; FSM and registers stay in lsu_ctrl.
// TESTING
//  1 SW addr 0x10 data 0xDEADBEEF, ack in 1st request cycle -> mem_addr 0x10, wstrb 1111, wdata 0xDEADBEEF; resp_valid in the cycle after the ack.
//  2 LB addr 0x13, rdata 0x80123456 -> resp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
//  3 SH addr 0x0E data 0x0000ABCD -> wstrb 1100, wdata 0xABCD0000; LH same addr, rdata 0x7FFF0000 -> 0x00007FFF.
//  4 LW addr 0x21, ack after 3 waits; split on: beats 0x20 then 0x24, rd0=0x44332211, rd1=0x88776655 -> 0x55443322; split off: resp_err=1, no mem_req.
//  5 Size 11 load -> resp_err=1, no mem_req. Reset asserted in a BEAT0 wait -> mem_req=0, req_ready=1 next cycle, no resp_valid.
//  6 mem_ack pulsed in IDLE, and req_valid held during RESP -> ignored; next request accepted only in IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared constants and helpers for the load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int              ST_W     = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_BEAT0 = 2'd1;
    localparam logic [ST_W-1:0] ST_BEAT1 = 2'd2;
    localparam logic [ST_W-1:0] ST_RESP  = 2'd3;

    // Byte enables across two consecutive words, lowest word in [3:0].
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            SZ_B:    base = 8'h01;
            SZ_H:    base = 8'h03;
            SZ_W:    base = 8'h0F;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == SZ_H) && (off == 2'd3)) || ((size == SZ_W) && (off != 2'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Store lane positioning/strobes and load extraction/extension.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        hi,
    input  logic [31:0] wdata,
    input  logic [31:0] rd0,
    input  logic [23:0] rd1,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  w_mask;
    logic [63:0] w_wdata64;
    logic [31:0] w_word;
    logic        w_sign;

    always_comb begin
        w_mask     = lane_mask(funct3[1:0], off);
        w_wdata64  = {32'h0, wdata} << {off, 3'b000};
        wstrb      = hi ? w_mask[7:4] : w_mask[3:0];
        wdata_lane = hi ? w_wdata64[63:32] : w_wdata64[31:0];

        // The top byte of the second word can never reach the low 32 result bits.
        case (off)
            2'd0:    w_word = rd0;
            2'd1:    w_word = {rd1[7:0],  rd0[31:8]};
            2'd2:    w_word = {rd1[15:0], rd0[31:16]};
            default: w_word = {rd1[23:0], rd0[31:24]};
        endcase

        w_sign = ~funct3[2];
        case (funct3[1:0])
            SZ_B:    load_data = {{24{w_sign & w_word[7]}},  w_word[7:0]};
            SZ_H:    load_data = {{16{w_sign & w_word[15]}}, w_word[15:0]};
            SZ_W:    load_data = w_word;
            default: load_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : Load/store unit driving a multi-cycle data memory.
//             LSU_MISALIGN_SPLIT_EN splits misaligned H/W into two word beats.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    logic [ST_W-1:0]       state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [31:0]           rd0_q, rd0_d;

    logic                  w_accept;
    logic                  w_req_mis;
    logic                  w_req_bad;
    logic                  w_hi;
    logic [23:0]           w_rd1;
    logic                  w_in_beat;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [3:0]            w_lane_strb;
    logic [31:0]           w_lane_wdata;
    logic [31:0]           w_load_data;

    assign w_accept    = req_valid && (state_q == ST_IDLE);
    assign w_req_mis   = is_misaligned(req_funct3[1:0], req_addr[1:0]);
    assign w_word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        split_q, split_d;
    logic [23:0] rd1_q, rd1_d;

    assign w_req_bad = (req_funct3[1:0] == 2'b11);
    assign w_hi      = (state_q == ST_BEAT1);
    assign w_rd1     = rd1_q;
`else
    assign w_req_bad = (req_funct3[1:0] == 2'b11) || w_req_mis;
    assign w_hi      = 1'b0;
    assign w_rd1     = 24'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = w_req_bad ? ST_RESP : ST_BEAT0;
            ST_BEAT0: if (mem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d = split_q ? ST_BEAT1 : ST_RESP;
`else
                state_d = ST_RESP;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_BEAT1: if (mem_ack) state_d = ST_RESP;
`endif
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rd0_q    <= 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q  <= 1'b0;
            rd1_q    <= 24'h0;
`endif
        end else begin
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rd0_q    <= rd0_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q  <= split_d;
            rd1_q    <= rd1_d;
`endif
        end
    end

    always_comb begin
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rd0_d    = rd0_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_d  = split_q;
        rd1_d    = rd1_q;
`endif
        if (w_accept) begin
            we_d     = req_we;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            err_d    = w_req_bad;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_d  = w_req_mis;
            rd1_d    = 24'h0;
`endif
        end
        if ((state_q == ST_BEAT0) && mem_ack) rd0_d = mem_rdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        if ((state_q == ST_BEAT1) && mem_ack) rd1_d = mem_rdata[23:0];
`endif
    end

    lsu_align u_align (
        .funct3     (funct3_q),
        .off        (addr_q[1:0]),
        .hi         (w_hi),
        .wdata      (wdata_q),
        .rd0        (rd0_q),
        .rd1        (w_rd1),
        .wstrb      (w_lane_strb),
        .wdata_lane (w_lane_wdata),
        .load_data  (w_load_data)
    );

    always_comb begin
        req_ready = (state_q == ST_IDLE);
`ifdef LSU_MISALIGN_SPLIT_EN
        w_in_beat = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
`else
        w_in_beat = (state_q == ST_BEAT0);
`endif
        mem_req  = w_in_beat;
        mem_we   = w_in_beat && we_q;
        mem_addr = '0;
        if (state_q == ST_BEAT0) mem_addr = w_word_addr;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_q == ST_BEAT1) mem_addr = w_word_addr + ADDR_WIDTH'(4);
`endif
        mem_wstrb  = mem_we ? w_lane_strb : 4'h0;
        mem_wdata  = mem_we ? w_lane_wdata : '0;
        resp_valid = (state_q == ST_RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !we_q && !err_q) ? w_load_data : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Self-checking bench for lsu_ctrl (vectors, random vs. byte model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk, reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    lsu_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Byte memories: one written by the DUT through the bus, one by the model.
    logic [7:0] dut_mem [256];
    logic [7:0] ref_mem [256];
    bit         use_mem;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [7:0] b;
        b = {a[7:2], 2'b00};
        return {dut_mem[b + 8'd3], dut_mem[b + 8'd2], dut_mem[b + 8'd1], dut_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        int          n;
        v = 32'h0;
        n = 1 << f3[1:0];
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    // Results of the last transaction.
    int          n_beats;
    logic [31:0] beat_addr  [2];
    logic [3:0]  beat_strb  [2];
    logic [31:0] beat_wdata [2];
    logic        beat_we    [2];
    logic        got_valid, got_err, lat_ok, stable_ok, timed_out;
    logic [31:0] got_rdata;

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        int          cyc, w, last_ack;
        bit          done;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_strb;
        logic        c_we;
        n_beats = 0; got_valid = 0; got_err = 0; got_rdata = 0;
        lat_ok = 1; stable_ok = 1; timed_out = 0;
        c_addr = 0; c_wdata = 0; c_strb = 0; c_we = 0;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 0;
        cyc = 1; w = 0; done = 0; last_ack = -10;
        while (!done && cyc < 60) begin
            mem_ack = 0;
            if (resp_valid) begin
                got_valid = 1; got_rdata = resp_rdata; got_err = resp_err;
                if (n_beats > 0 && cyc != last_ack + 1) lat_ok = 0;
                if (n_beats == 0 && cyc != 1) lat_ok = 0;
                done = 1;
            end else if (mem_req) begin
                if (n_beats == 0 && w == 0 && cyc != 1) lat_ok = 0;
                if (w == 0) begin
                    c_addr = mem_addr; c_wdata = mem_wdata; c_strb = mem_wstrb; c_we = mem_we;
                end else if (c_addr !== mem_addr || c_wdata !== mem_wdata ||
                             c_strb !== mem_wstrb || c_we !== mem_we) begin
                    stable_ok = 0;
                end
                if (w == waits) begin
                    mem_ack   = 1;
                    mem_rdata = use_mem ? mem_word(mem_addr) : ((n_beats == 0) ? rd0 : rd1);
                    if (n_beats < 2) begin
                        beat_addr[n_beats] = mem_addr; beat_strb[n_beats] = mem_wstrb;
                        beat_wdata[n_beats] = mem_wdata; beat_we[n_beats] = mem_we;
                    end
                    if (use_mem && mem_we)
                        for (int i = 0; i < 4; i++)
                            if (mem_wstrb[i]) dut_mem[8'(mem_addr + 32'(i))] = mem_wdata[8*i +: 8];
                    n_beats++;
                    w = 0;
                    last_ack = cyc;
                end else begin
                    w++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 0;
        if (!done) timed_out = 1;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, rd0, rd1;
        int          waits, beats;
        logic        err;
        logic [31:0] rdata, addr0, addr1;
        logic [3:0]  strb0, strb1;
        logic [31:0] wdata0, wdata1;
    } vec_t;

    function automatic vec_t mkv(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                 logic [31:0] rd0, logic [31:0] rd1, int waits, int beats,
                                 logic err, logic [31:0] rdata, logic [31:0] addr0,
                                 logic [31:0] addr1, logic [3:0] strb0, logic [3:0] strb1,
                                 logic [31:0] wdata0, logic [31:0] wdata1);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
        v.waits = waits; v.beats = beats; v.err = err; v.rdata = rdata;
        v.addr0 = addr0; v.addr1 = addr1; v.strb0 = strb0; v.strb1 = strb1;
        v.wdata0 = wdata0; v.wdata1 = wdata1;
        return v;
    endfunction

    vec_t vecs [11];

    initial begin
        int          bad_cnt;
        logic        rv_seen;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wdata, exp_rd;
        logic        mis, exp_err;
        int          exp_beats;

        vecs[0]  = mkv(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 32'h10, 0, 4'hF, 0, 32'hDEADBEEF, 0);
        vecs[1]  = mkv(0, 3'b000, 32'h13, 0, 32'h80123456, 0, 0, 1, 0, 32'hFFFFFF80, 32'h10, 0, 0, 0, 0, 0);
        vecs[2]  = mkv(0, 3'b100, 32'h13, 0, 32'h80123456, 0, 1, 1, 0, 32'h00000080, 32'h10, 0, 0, 0, 0, 0);
        vecs[3]  = mkv(1, 3'b001, 32'h0E, 32'h0000ABCD, 0, 0, 0, 1, 0, 0, 32'h0C, 0, 4'hC, 0, 32'hABCD0000, 0);
        vecs[4]  = mkv(0, 3'b001, 32'h0E, 0, 32'h7FFF0000, 0, 2, 1, 0, 32'h00007FFF, 32'h0C, 0, 0, 0, 0, 0);
        vecs[5]  = SPLIT ? mkv(0, 3'b010, 32'h21, 0, 32'h44332211, 32'h88776655, 3, 2, 0, 32'h55443322, 32'h20, 32'h24, 0, 0, 0, 0)
                         : mkv(0, 3'b010, 32'h21, 0, 32'h44332211, 32'h88776655, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = mkv(0, 3'b011, 32'h40, 0, 32'h12345678, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = SPLIT ? mkv(1, 3'b001, 32'h0F, 32'h0000ABCD, 0, 0, 1, 2, 0, 0, 32'h0C, 32'h10, 4'h8, 4'h1, 32'hCD000000, 32'h000000AB)
                         : mkv(1, 3'b001, 32'h0F, 32'h0000ABCD, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[8]  = SPLIT ? mkv(0, 3'b010, 32'hFFFFFFFE, 0, 32'h11223344, 32'h55667788, 0, 2, 0, 32'h77881122, 32'hFFFFFFFC, 32'h0, 0, 0, 0, 0)
                         : mkv(0, 3'b010, 32'hFFFFFFFE, 0, 32'h11223344, 32'h55667788, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mkv(0, 3'b001, 32'h12, 0, 32'h80010000, 0, 0, 1, 0, 32'hFFFF8001, 32'h10, 0, 0, 0, 0, 0);
        vecs[10] = mkv(1, 3'b000, 32'h07, 32'h000000A5, 0, 0, 2, 1, 0, 0, 32'h04, 0, 4'h8, 0, 32'hA5000000, 0);

        reset = 1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
        mem_ack = 0; mem_rdata = 0; use_mem = 0;
        for (int i = 0; i < 256; i++) begin
            dut_mem[i] = 8'($urandom);
            ref_mem[i] = dut_mem[i];
        end
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                    vecs[i].rd0, vecs[i].rd1);
            chk($sformatf("v%0d_timeout", i), {31'h0, timed_out}, 32'h0);
            chk($sformatf("v%0d_err", i), {31'h0, got_err}, {31'h0, vecs[i].err});
            chk($sformatf("v%0d_rdata", i), got_rdata, vecs[i].rdata);
            chk($sformatf("v%0d_beats", i), 32'(n_beats), 32'(vecs[i].beats));
            chk($sformatf("v%0d_latency", i), {31'h0, lat_ok}, 32'h1);
            chk($sformatf("v%0d_stable", i), {31'h0, stable_ok}, 32'h1);
            if (n_beats >= 1 && vecs[i].beats >= 1) begin
                chk($sformatf("v%0d_addr0", i), beat_addr[0], vecs[i].addr0);
                chk($sformatf("v%0d_we0", i), {31'h0, beat_we[0]}, {31'h0, vecs[i].we});
                chk($sformatf("v%0d_strb0", i), {28'h0, beat_strb[0]}, {28'h0, vecs[i].strb0});
                if (vecs[i].we) chk($sformatf("v%0d_wdata0", i), beat_wdata[0], vecs[i].wdata0);
            end
            if (n_beats >= 2 && vecs[i].beats >= 2) begin
                chk($sformatf("v%0d_addr1", i), beat_addr[1], vecs[i].addr1);
                chk($sformatf("v%0d_strb1", i), {28'h0, beat_strb[1]}, {28'h0, vecs[i].strb1});
                if (vecs[i].we) chk($sformatf("v%0d_wdata1", i), beat_wdata[1], vecs[i].wdata1);
            end
        end

        // mem_ack while idle must do nothing.
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        chk("idle_ack_mem_req", {31'h0, mem_req}, 32'h0);
        chk("idle_ack_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("idle_ack_req_ready", {31'h0, req_ready}, 32'h1);

        // req_valid held through a whole access: no accept in the RESP cycle.
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 0;
        @(negedge clk);
        chk("hold_beat_mem_req", {31'h0, mem_req}, 32'h1);
        mem_ack = 1; mem_rdata = 32'h12345678;
        @(negedge clk);
        mem_ack = 0;
        chk("hold_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("hold_resp_rdata", resp_rdata, 32'h12345678);
        chk("hold_resp_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        chk("hold_idle_ready", {31'h0, req_ready}, 32'h1);
        chk("hold_idle_mem_req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        req_valid = 0;
        chk("hold_second_mem_req", {31'h0, mem_req}, 32'h1);
        mem_ack = 1; mem_rdata = 32'h0;
        @(negedge clk);
        mem_ack = 0;
        chk("hold_second_resp", {31'h0, resp_valid}, 32'h1);
        @(negedge clk);

        // Reset during a BEAT0 wait abandons the access.
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h30;
        @(negedge clk);
        req_valid = 0;
        chk("rstw_mem_req", {31'h0, mem_req}, 32'h1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rstw_mem_req_drop", {31'h0, mem_req}, 32'h0);
        chk("rstw_req_ready", {31'h0, req_ready}, 32'h1);
        rv_seen = resp_valid;
        repeat (3) begin
            @(negedge clk);
            rv_seen = rv_seen | resp_valid | mem_req;
        end
        chk("rstw_no_resp", {31'h0, rv_seen}, 32'h0);

        // Random accesses against a byte-addressed memory model.
        use_mem = 1;
        for (int it = 0; it < 60; it++) begin
            we    = 1'($urandom_range(0, 1));
            f3[1:0] = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
            f3[2] = we ? 1'b0 : 1'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, 255));
            wdata = $urandom;
            mis       = (f3[1:0] == 2'b01 && addr[1:0] == 2'd3) || (f3[1:0] == 2'b10 && addr[1:0] != 2'd0);
            exp_err   = (f3[1:0] == 2'b11) || (mis && !SPLIT);
            exp_beats = exp_err ? 0 : (mis ? 2 : 1);
            exp_rd    = 32'h0;
            if (!exp_err) begin
                if (we) begin
                    for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[8'(addr + 32'(i))] = wdata[8*i +: 8];
                end else begin
                    exp_rd = ref_load(f3, addr);
                end
            end
            run_txn(we, f3, addr, wdata, int'($urandom_range(0, 3)), 0, 0);
            chk($sformatf("r%0d_timeout", it), {31'h0, timed_out}, 32'h0);
            chk($sformatf("r%0d_err", it), {31'h0, got_err}, {31'h0, exp_err});
            chk($sformatf("r%0d_rdata", it), got_rdata, exp_rd);
            chk($sformatf("r%0d_beats", it), 32'(n_beats), 32'(exp_beats));
            chk($sformatf("r%0d_latency", it), {31'h0, lat_ok}, 32'h1);
            chk($sformatf("r%0d_stable", it), {31'h0, stable_ok}, 32'h1);
            if (n_beats >= 1 && exp_beats >= 1) begin
                chk($sformatf("r%0d_addr0", it), beat_addr[0], {addr[31:2], 2'b00});
                chk($sformatf("r%0d_we0", it), {31'h0, beat_we[0]}, {31'h0, we});
                if (!we) chk($sformatf("r%0d_strb0", it), {28'h0, beat_strb[0]}, 32'h0);
            end
            if (n_beats >= 2 && exp_beats >= 2)
                chk($sformatf("r%0d_addr1", it), beat_addr[1], {addr[31:2], 2'b00} + 32'd4);
            bad_cnt = 0;
            for (int i = 0; i < 256; i++) if (dut_mem[i] !== ref_mem[i]) bad_cnt++;
            chk($sformatf("r%0d_mem", it), 32'(bad_cnt), 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
